// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time, stalls the pipeline while it is in
// flight and acknowledges it exactly LATENCY cycles after acceptance.
// Optional feature macro: DMEM_BYTE_MASK_EN adds the be_i byte-enable port
// and turns stores into per-byte writes.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  // Latched copy of the accepted request
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic        rd_reg;
  logic        wr_reg;
  logic [3:0]  be_reg;

  logic        valid;
  logic        accept;
  logic        finish;
  logic        sel_inputs;
  logic [3:0]  in_be;

  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic        cur_rd;
  logic        cur_wr;
  logic [3:0]  cur_be;
  logic        cur_err;
  logic [AW-1:0] cur_idx;

  logic        store_commit;
  logic [3:0]  byte_we;

  logic [31:0] mem_reg [DEPTH];

`ifdef DMEM_BYTE_MASK_EN
  assign in_be = be_i;
`else
  assign in_be = 4'hF;
`endif

  assign valid = req_i & (MemRead_i | MemWrite_i);

  // With LATENCY=1 the request completes on the accepting edge, so the
  // operation must come straight from the inputs while still in IDLE.
  assign sel_inputs = (state_reg == IDLE);
  assign cur_addr   = sel_inputs ? addr_i     : addr_reg;
  assign cur_data   = sel_inputs ? data_i     : data_reg;
  assign cur_rd     = sel_inputs ? MemRead_i  : rd_reg;
  assign cur_wr     = sel_inputs ? MemWrite_i : wr_reg;
  assign cur_be     = sel_inputs ? in_be      : be_reg;
  assign cur_idx    = cur_addr[AW+1:2];

  // Misaligned, beyond the array, or both load and store requested
  assign cur_err = (cur_addr[1:0] != 2'b00)
                 | ({2'b00, cur_addr[31:2]} >= 32'(DEPTH))
                 | (cur_rd & cur_wr);

  // A reset on the completing edge discards the pending store
  assign store_commit = finish & cur_wr & ~cur_err & ~rst_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
      assign byte_we[gi] = store_commit & cur_be[gi];
    end
  endgenerate

  // State and countdown register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, countdown and stall decode
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_o    = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        stall_o = valid;
        if (valid) begin
          accept   = 1'b1;
          cnt_next = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next = COMPLETE;
            finish     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o  = 1'b1;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = COMPLETE;
          finish     = 1'b1;
        end
      end
      COMPLETE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request on acceptance so BUSY ignores input changes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg <= 32'd0;
      data_reg <= 32'd0;
      rd_reg   <= 1'b0;
      wr_reg   <= 1'b0;
      be_reg   <= 4'd0;
    end else if (accept) begin
      addr_reg <= addr_i;
      data_reg <= data_i;
      rd_reg   <= MemRead_i;
      wr_reg   <= MemWrite_i;
      be_reg   <= in_be;
    end
  end

  // Storage array write port; byte lanes written independently
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_we[b]) begin
        mem_reg[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  // Registered read data and completion flags, set on the edge into COMPLETE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= 32'd0;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      ack_o <= finish;
      err_o <= finish & cur_err;
      if (finish) begin
        if (cur_err) begin
          data_o <= 32'd0;
        end else if (cur_rd) begin
          data_o <= mem_reg[cur_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=3 (index 0) and one at
// LATENCY=1 (index 1), checked against a word-array reference model.
module tb_dmem_responder;

`ifdef DMEM_BYTE_MASK_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        req   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];

  logic [31:0] mdl [2][64];
  int          lat [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .MemRead_i(rd[0]),
    .MemWrite_i(wr[0]), .addr_i(addr[0]), .data_i(wdata[0]),
`ifdef DMEM_BYTE_MASK_EN
    .be_i(be[0]),
`endif
    .data_o(rdata[0]), .ack_o(ack[0]), .stall_o(stall[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .MemRead_i(rd[1]),
    .MemWrite_i(wr[1]), .addr_i(addr[1]), .data_i(wdata[1]),
`ifdef DMEM_BYTE_MASK_EN
    .be_i(be[1]),
`endif
    .data_o(rdata[1]), .ack_o(ack[1]), .stall_o(stall[1]), .err_o(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    req[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
    addr[d] = 32'd0; wdata[d] = 32'd0; be[d] = 4'h0;
  endtask

  // Entry and exit: #1 after a rising edge, DUT in IDLE
  task automatic txn(input int d, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] v, input logic [3:0] b);
    logic        e;
    logic [31:0] exp_data;
    int          idx;
    int          n;
    n   = lat[d];
    idx = int'(a / 32'd4);
    e   = (a % 32'd4 != 0) || (a / 32'd4 >= 32'd1024) || (r && w);
    exp_data = (e || idx >= 64) ? 32'd0 : mdl[d][idx];
    req[d] = 1'b1; rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = v; be[d] = b;
    #1;
    check($sformatf("stall_accept_d%0d", d), stall[d], 1);
    check($sformatf("ack_accept_d%0d", d), ack[d], 0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c < n) begin
        check($sformatf("stall_busy_d%0d_c%0d", d, c), stall[d], 1);
        check($sformatf("ack_busy_d%0d_c%0d", d, c), ack[d], 0);
        if (c == 1) begin
          addr[d]  = $urandom;
          wdata[d] = $urandom;
          be[d]    = 4'($urandom);
        end
      end else begin
        check($sformatf("ack_done_d%0d", d), ack[d], 1);
        check($sformatf("stall_done_d%0d", d), stall[d], 0);
        check($sformatf("err_done_d%0d", d), err[d], e);
        if (r) check($sformatf("rdata_d%0d_a%h", d, a), rdata[d], exp_data);
      end
    end
    $display("txn dut%0d rd=%0b wr=%0b addr=%h wdata=%h be=%h -> ack=%0b err=%0b rdata=%h",
             d, r, w, a, v, b, ack[d], err[d], rdata[d]);
    if (w && !e) begin
      for (int k = 0; k < 4; k++) begin
        if (!BE_EN || b[k]) mdl[d][idx][8*k +: 8] = v[8*k +: 8];
      end
    end
    idle_inputs(d);
    @(posedge clk); #1;
    check($sformatf("ack_drop_d%0d", d), ack[d], 0);
    check($sformatf("err_drop_d%0d", d), err[d], 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  b;
    logic        r;
    logic        w;
    int          d;
    int          kind;
    lat[0] = 3;
    lat[1] = 1;
    for (int i = 0; i < 2; i++) begin
      idle_inputs(i);
      rst[i] = 1'b1;
      for (int j = 0; j < 64; j++) mdl[i][j] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_data_d%0d", i), rdata[i], 0);
      check($sformatf("rst_ack_d%0d", i), ack[i], 0);
      check($sformatf("rst_err_d%0d", i), err[i], 0);
      check($sformatf("rst_stall_d%0d", i), stall[i], 0);
      rst[i] = 1'b0;
    end
    @(posedge clk); #1;

    // Known contents for words 0..15 of both instances
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        txn(i, 1'b0, 1'b1, 32'(j * 4), $urandom, 4'hF);

    // Store then load at LATENCY=3
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);

    // Back-to-back loads at LATENCY=1
    txn(1, 1'b0, 1'b1, 32'h0, 32'h11, 4'hF);
    txn(1, 1'b0, 1'b1, 32'h4, 32'h22, 4'hF);
    txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);

    // Error cases; word 0 must survive the out-of-range store
    txn(0, 1'b0, 1'b1, 32'h0, 32'h55, 4'hF);
    txn(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'hF);
    txn(0, 1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF);
    txn(0, 1'b1, 1'b1, 32'h4, 32'h87654321, 4'hF);
    txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    txn(1, 1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF);
    txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);

    // Reset during BUSY of a store: aborted, no ack, old value kept
    txn(0, 1'b0, 1'b1, 32'h20, 32'h00001234, 4'hF);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20;
    wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    @(posedge clk); #1;
    check("abort_stall_busy", stall[0], 1);
    rst[0] = 1'b1;
    idle_inputs(0);
    @(posedge clk); #1;
    check("abort_ack", ack[0], 0);
    check("abort_data", rdata[0], 0);
    check("abort_err", err[0], 0);
    check("abort_stall", stall[0], 0);
    rst[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort_no_ack", ack[0], 0);
    end
    $display("txn dut0 reset-abort store addr=00000020 -> ack=%0b", ack[0]);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);

    // Request with neither load nor store: ignored
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0; addr[0] = 32'h8;
    #1;
    check("noop_stall", stall[0], 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("noop_ack", ack[0], 0);
      check("noop_stall_hold", stall[0], 0);
    end
    $display("txn dut0 no-op request addr=00000008 -> ack=%0b stall=%0b", ack[0], stall[0]);
    idle_inputs(0);
    @(posedge clk); #1;

`ifdef DMEM_BYTE_MASK_EN
    // Partial store into a cleared word, and an all-zero mask
    txn(0, 1'b0, 1'b1, 32'h8, 32'h0, 4'hF);
    txn(0, 1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    check("be_partial_value", rdata[0], 32'h00BB00DD);
    txn(1, 1'b0, 1'b1, 32'hC, 32'h99999999, 4'h0);
    txn(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
`endif

    // Randomized mix on both instances
    for (int i = 0; i < 60; i++) begin
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      r    = 1'($urandom_range(0, 1));
      w    = ~r;
      v    = $urandom;
      b    = BE_EN ? 4'($urandom) : 4'hF;
      a    = 32'($urandom_range(0, 15) * 4);
      case (kind)
        0: a = a | 32'($urandom_range(1, 3));
        1: a = 32'($urandom_range(1024, 4095) * 4);
        2: begin r = 1'b1; w = 1'b1; end
        default: ;
      endcase
      txn(d, r, w, a, v, b);
    end

    // Read back every tracked word
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        txn(i, 1'b1, 1'b0, 32'(j * 4), 32'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
